register_file: RTL and testbench

//  32 x 32-bit general-purpose register file feeding the execute-stage ALU operands A and B.
//  Two combinational read ports, one synchronous write port from writeback.

---
 rtl/regfile_pkg.sv | 19 +
 rtl/reg_word.sv | 30 +++
 rtl/register_file.sv | 90 +++++++++
 tb/tb_register_file.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and types for the general-purpose register file.
//
// Contents:
//   DATA_W   - width of each register and of all data ports
//   NUM_REGS - number of architectural registers (power of two)
//   ADDR_W   - log2(NUM_REGS), width of every register index
//   ZERO_REG - index of the hardwired-zero register
//   reg_addr_t / reg_data_t - register index and register value types
package regfile_pkg;

    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 32;
    localparam int ADDR_W   = 5;
    localparam int ZERO_REG = 0;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/reg_word.sv
// One architectural register: DATA_W-bit storage with load enable and
// synchronous active-high clear.
//
// Ports:
//   clock - rising-edge clock
//   reset - synchronous active-high clear; has priority over en
//   en    - load d on the next rising edge
//   d     - value to load
//   q     - stored value
module reg_word
    import regfile_pkg::*;
#(
    parameter int W = DATA_W
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clock) begin
        if (reset) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/register_file.sv
// 32 x 32-bit general-purpose register file feeding the ALU operands.
// Two combinational read ports, one synchronous write port; register 0
// always reads zero.
//
// Optional feature macro: REGFILE_BYPASS_EN
//   defined   - a read of the register being written in the same cycle
//               returns wr_data (write-through forwarding); reset=1 makes
//               a colliding port return 0; index 0 never forwards.
//   undefined - a colliding read returns the old register value; the new
//               value appears the next cycle.
//
// Ports:
//   clock     - rising-edge clock, sole domain
//   reset     - synchronous active-high; clears r1..r31, drops a same-edge write
//   wr_en     - write enable from writeback
//   wr_addr   - destination register index
//   wr_data   - value to write
//   rd_addr_a - source index for operand A
//   rd_addr_b - source index for operand B
//   data_a    - contents of rd_addr_a
//   data_b    - contents of rd_addr_b
module register_file
    import regfile_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] data_a,
    output logic [DATA_W-1:0] data_b
);

    // One-hot write select covering indices 1..NUM_REGS-1. Register 0 has
    // no storage, so a write to index 0 selects nothing.
    logic [NUM_REGS-1:1] wr_sel;

    always_comb begin
        wr_sel = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            wr_sel[i] = wr_en && (wr_addr == ADDR_W'(i));
        end
    end

    reg_data_t regs [NUM_REGS];

    assign regs[ZERO_REG] = '0;

    for (genvar g = 1; g < NUM_REGS; g++) begin : g_word
        reg_word #(.W(DATA_W)) u_word (
            .clock (clock),
            .reset (reset),
            .en    (wr_sel[g]),
            .d     (wr_data),
            .q     (regs[g])
        );
    end

    reg_data_t mux_a;
    reg_data_t mux_b;

    assign mux_a = regs[rd_addr_a];
    assign mux_b = regs[rd_addr_b];

`ifdef REGFILE_BYPASS_EN
    // A collision needs a live write to a real register at the same index.
    logic hit_a;
    logic hit_b;

    assign hit_a = wr_en && (wr_addr != ADDR_W'(ZERO_REG)) && (rd_addr_a == wr_addr);
    assign hit_b = wr_en && (wr_addr != ADDR_W'(ZERO_REG)) && (rd_addr_b == wr_addr);

    always_comb begin
        data_a = mux_a;
        data_b = mux_b;
        if (hit_a) begin
            data_a = reset ? '0 : wr_data;
        end
        if (hit_b) begin
            data_b = reset ? '0 : wr_data;
        end
    end
`else
    assign data_a = mux_a;
    assign data_b = mux_b;
`endif

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file. A reference array holds what each
// register must contain; every read check pushes its expected operands to
// exp_q when the addresses are driven and pops them when the outputs are
// sampled (1 time unit later, away from the clock edge).
module tb_register_file;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 32;

    logic          clock;
    logic          reset;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [AW-1:0] rd_addr_a;
    logic [AW-1:0] rd_addr_b;
    logic [DW-1:0] data_a;
    logic [DW-1:0] data_b;

    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] model [NR];

    int tests_run;
    int tests_failed;

    register_file dut (
        .clock     (clock),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .data_a    (data_a),
        .data_b    (data_b)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, run did not complete");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    // Present a write at the falling edge, let it take effect on the rising edge.
    task automatic drive_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clock);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        @(posedge clock);
        #1;
        wr_en = 1'b0;
        if (a != 0) model[a] = d;
    endtask

    task automatic drive_reset(input int cycles);
        @(negedge clock);
        reset = 1'b1;
        repeat (cycles) @(posedge clock);
        #1;
        reset = 1'b0;
        for (int i = 0; i < NR; i++) model[i] = '0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        logic [DW-1:0] e;
        // All registers must read 0 after the initial reset.
        for (int i = 0; i < NR; i++) begin
            @(negedge clock);
            rd_addr_a = AW'(i);
            rd_addr_b = AW'(NR - 1 - i);
            exp_q.push_back(32'h0);
            exp_q.push_back(32'h0);
            #1;
            e = exp_q.pop_front();
            tests_run++;
            if (data_a !== e) begin
                tests_failed++;
                $display("FAIL reset_clear_a r%0d: got %h expected %h", i, data_a, e);
            end
            e = exp_q.pop_front();
            tests_run++;
            if (data_b !== e) begin
                tests_failed++;
                $display("FAIL reset_clear_b r%0d: got %h expected %h", NR - 1 - i, data_b, e);
            end
        end
        // Written value is lost through a one-cycle reset.
        drive_write(5'd5, 32'hDEADBEEF);
        @(negedge clock);
        rd_addr_a = 5'd5;
        exp_q.push_back(32'hDEADBEEF);
        #1;
        e = exp_q.pop_front();
        tests_run++;
        if (data_a !== e) begin
            tests_failed++;
            $display("FAIL pre_reset_r5: got %h expected %h", data_a, e);
        end
        drive_reset(1);
        @(negedge clock);
        rd_addr_a = 5'd5;
        exp_q.push_back(32'h0);
        #1;
        e = exp_q.pop_front();
        tests_run++;
        if (data_a !== e) begin
            tests_failed++;
            $display("FAIL reset_clear_r5: got %h expected %h", data_a, e);
        end
    endtask

    task automatic test_basic_write;
        logic [DW-1:0] e;
        drive_write(5'd7, 32'h12345678);
        @(negedge clock);
        rd_addr_a = 5'd7;
        rd_addr_b = 5'd7;
        exp_q.push_back(32'h12345678);
        exp_q.push_back(32'h12345678);
        #1;
        e = exp_q.pop_front();
        tests_run++;
        if (data_a !== e) begin
            tests_failed++;
            $display("FAIL basic_r7_a: got %h expected %h", data_a, e);
        end
        e = exp_q.pop_front();
        tests_run++;
        if (data_b !== e) begin
            tests_failed++;
            $display("FAIL basic_r7_b: got %h expected %h", data_b, e);
        end
    endtask

    task automatic test_zero_reg;
        logic [DW-1:0] e;
        drive_write(5'd0, 32'hFFFFFFFF);
        @(negedge clock);
        rd_addr_a = 5'd0;
        rd_addr_b = 5'd0;
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        #1;
        e = exp_q.pop_front();
        tests_run++;
        if (data_a !== e) begin
            tests_failed++;
            $display("FAIL zero_reg_a: got %h expected %h", data_a, e);
        end
        e = exp_q.pop_front();
        tests_run++;
        if (data_b !== e) begin
            tests_failed++;
            $display("FAIL zero_reg_b: got %h expected %h", data_b, e);
        end
    endtask

    task automatic test_collision;
        logic [DW-1:0] e;
        drive_write(5'd3, 32'h11111111);
        @(negedge clock);
        wr_en     = 1'b1;
        wr_addr   = 5'd3;
        wr_data   = 32'h22222222;
        rd_addr_a = 5'd3;
        rd_addr_b = 5'd7;
`ifdef REGFILE_BYPASS_EN
        exp_q.push_back(32'h22222222);
`else
        exp_q.push_back(32'h11111111);
`endif
        exp_q.push_back(model[7]);
        #1;
        e = exp_q.pop_front();
        tests_run++;
        if (data_a !== e) begin
            tests_failed++;
            $display("FAIL collision_same_cycle: got %h expected %h", data_a, e);
        end
        e = exp_q.pop_front();
        tests_run++;
        if (data_b !== e) begin
            tests_failed++;
            $display("FAIL collision_other_port: got %h expected %h", data_b, e);
        end
        @(posedge clock);
        #1;
        wr_en = 1'b0;
        model[3] = 32'h22222222;
        exp_q.push_back(32'h22222222);
        #1;
        e = exp_q.pop_front();
        tests_run++;
        if (data_a !== e) begin
            tests_failed++;
            $display("FAIL collision_next_cycle: got %h expected %h", data_a, e);
        end
    endtask

    task automatic test_reset_vs_write;
        logic [DW-1:0] e;
        @(negedge clock);
        reset     = 1'b1;
        wr_en     = 1'b1;
        wr_addr   = 5'd9;
        wr_data   = 32'hA5A5A5A5;
        rd_addr_a = 5'd7;
        rd_addr_b = 5'd7;
        @(posedge clock);
        #1;
        reset = 1'b0;
        wr_en = 1'b0;
        for (int i = 0; i < NR; i++) model[i] = '0;
        @(negedge clock);
        rd_addr_a = 5'd9;
        rd_addr_b = 5'd3;
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        #1;
        e = exp_q.pop_front();
        tests_run++;
        if (data_a !== e) begin
            tests_failed++;
            $display("FAIL reset_wins_r9: got %h expected %h", data_a, e);
        end
        e = exp_q.pop_front();
        tests_run++;
        if (data_b !== e) begin
            tests_failed++;
            $display("FAIL reset_clears_r3: got %h expected %h", data_b, e);
        end
        // Writes resume on the first edge with reset low.
        drive_write(5'd9, 32'h5A5A5A5A);
        @(negedge clock);
        rd_addr_a = 5'd9;
        exp_q.push_back(32'h5A5A5A5A);
        #1;
        e = exp_q.pop_front();
        tests_run++;
        if (data_a !== e) begin
            tests_failed++;
            $display("FAIL write_after_reset_r9: got %h expected %h", data_a, e);
        end
    endtask

    task automatic test_sweep;
        logic [DW-1:0] e;
        for (int i = 1; i < NR; i++) begin
            drive_write(AW'(i), 32'(i) * 32'h01010101);
        end
        for (int i = 0; i < NR; i++) begin
            @(negedge clock);
            rd_addr_a = AW'(i);
            rd_addr_b = AW'(NR - 1 - i);
            exp_q.push_back(32'(i) * 32'h01010101);
            exp_q.push_back(32'(NR - 1 - i) * 32'h01010101);
            #1;
            e = exp_q.pop_front();
            tests_run++;
            if (data_a !== e) begin
                tests_failed++;
                $display("FAIL sweep_a r%0d: got %h expected %h", i, data_a, e);
            end
            e = exp_q.pop_front();
            tests_run++;
            if (data_b !== e) begin
                tests_failed++;
                $display("FAIL sweep_b r%0d: got %h expected %h", NR - 1 - i, data_b, e);
            end
        end
    endtask

    // A write every cycle with random reads checked against the reference.
    task automatic test_back_to_back;
        logic [DW-1:0] e;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        logic [AW-1:0] ra;
        logic [AW-1:0] rb;
        for (int n = 0; n < 200; n++) begin
            @(negedge clock);
            wa = AW'($urandom_range(0, NR - 1));
            wd = $urandom();
            ra = AW'($urandom_range(0, NR - 1));
            rb = (n % 4 == 0) ? wa : AW'($urandom_range(0, NR - 1));
            wr_en     = 1'b1;
            wr_addr   = wa;
            wr_data   = wd;
            rd_addr_a = ra;
            rd_addr_b = rb;
`ifdef REGFILE_BYPASS_EN
            exp_q.push_back((wa != 0 && ra == wa) ? wd : model[ra]);
            exp_q.push_back((wa != 0 && rb == wa) ? wd : model[rb]);
`else
            exp_q.push_back(model[ra]);
            exp_q.push_back(model[rb]);
`endif
            #1;
            e = exp_q.pop_front();
            tests_run++;
            if (data_a !== e) begin
                tests_failed++;
                $display("FAIL b2b_a iter %0d r%0d: got %h expected %h", n, ra, data_a, e);
            end
            e = exp_q.pop_front();
            tests_run++;
            if (data_b !== e) begin
                tests_failed++;
                $display("FAIL b2b_b iter %0d r%0d: got %h expected %h", n, rb, data_b, e);
            end
            @(posedge clock);
            #1;
            if (wa != 0) model[wa] = wd;
        end
        wr_en = 1'b0;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset     = 1'b1;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        rd_addr_a = '0;
        rd_addr_b = '0;
        for (int i = 0; i < NR; i++) model[i] = '0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;

        test_reset();
        test_basic_write();
        test_zero_reg();
        test_collision();
        test_reset_vs_write();
        test_sweep();
        test_back_to_back();

        if (exp_q.size() != 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL scoreboard_drain: got %0d leftover entries expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
